// File: rtl/tl_pkg.sv
// Shared TileLink constants for the crossbar arbiter: opcodes, field widths
// and arbiter state encodings.
package tl_pkg;

   localparam int unsigned TL_OPCODE_W  = 3;
   localparam int unsigned TL_A_PARAM_W = 3;
   localparam int unsigned TL_D_PARAM_W = 2;

   localparam logic [TL_OPCODE_W-1:0] TL_A_PUT_FULL    = 3'd0;
   localparam logic [TL_OPCODE_W-1:0] TL_A_PUT_PARTIAL = 3'd1;
   localparam logic [TL_OPCODE_W-1:0] TL_A_GET         = 3'd4;

   typedef logic [1:0] arb_state_t;
   localparam arb_state_t ST_IDLE  = 2'd0;
   localparam arb_state_t ST_HOLD  = 2'd1;
   localparam arb_state_t ST_BURST = 2'd2;

endpackage

// File: rtl/tl_xbar_arb_if.sv
// Client-side (packed per client) and manager-side TileLink A/D channels of
// the crossbar arbiter.
interface tl_xbar_arb_if
   import tl_pkg::*;
#(
   parameter int unsigned N_IN   = 4,
   parameter int unsigned SRC_W  = 5,
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned SIZE_W = 4
);
   localparam int unsigned IDX_W  = $clog2(N_IN);
   localparam int unsigned OSRC_W = SRC_W + IDX_W;
   localparam int unsigned MASK_W = DATA_W / 8;

   logic [N_IN-1:0]              in_a_valid;
   logic [N_IN-1:0]              in_a_ready;
   logic [N_IN*TL_OPCODE_W-1:0]  in_a_bits_opcode;
   logic [N_IN*TL_A_PARAM_W-1:0] in_a_bits_param;
   logic [N_IN*SIZE_W-1:0]       in_a_bits_size;
   logic [N_IN*SRC_W-1:0]        in_a_bits_source;
   logic [N_IN*ADDR_W-1:0]       in_a_bits_address;
   logic [N_IN*MASK_W-1:0]       in_a_bits_mask;
   logic [N_IN*DATA_W-1:0]       in_a_bits_data;
   logic [N_IN-1:0]              in_a_bits_corrupt;

   logic [N_IN-1:0]              in_d_valid;
   logic [N_IN-1:0]              in_d_ready;
   logic [TL_OPCODE_W-1:0]       in_d_bits_opcode;
   logic [TL_D_PARAM_W-1:0]      in_d_bits_param;
   logic [SIZE_W-1:0]            in_d_bits_size;
   logic [SRC_W-1:0]             in_d_bits_source;
   logic                         in_d_bits_sink;
   logic                         in_d_bits_denied;
   logic [DATA_W-1:0]            in_d_bits_data;
   logic                         in_d_bits_corrupt;

   logic                         out_a_valid;
   logic                         out_a_ready;
   logic [TL_OPCODE_W-1:0]       out_a_bits_opcode;
   logic [TL_A_PARAM_W-1:0]      out_a_bits_param;
   logic [SIZE_W-1:0]            out_a_bits_size;
   logic [OSRC_W-1:0]            out_a_bits_source;
   logic [ADDR_W-1:0]            out_a_bits_address;
   logic [MASK_W-1:0]            out_a_bits_mask;
   logic [DATA_W-1:0]            out_a_bits_data;
   logic                         out_a_bits_corrupt;

   logic                         out_d_valid;
   logic                         out_d_ready;
   logic [TL_OPCODE_W-1:0]       out_d_bits_opcode;
   logic [TL_D_PARAM_W-1:0]      out_d_bits_param;
   logic [SIZE_W-1:0]            out_d_bits_size;
   logic [OSRC_W-1:0]            out_d_bits_source;
   logic                         out_d_bits_sink;
   logic                         out_d_bits_denied;
   logic [DATA_W-1:0]            out_d_bits_data;
   logic                         out_d_bits_corrupt;

   // Arbiter side
   modport slave (
      input  in_a_valid, in_a_bits_opcode, in_a_bits_param, in_a_bits_size,
             in_a_bits_source, in_a_bits_address, in_a_bits_mask,
             in_a_bits_data, in_a_bits_corrupt, in_d_ready,
             out_a_ready, out_d_valid, out_d_bits_opcode, out_d_bits_param,
             out_d_bits_size, out_d_bits_source, out_d_bits_sink,
             out_d_bits_denied, out_d_bits_data, out_d_bits_corrupt,
      output in_a_ready, in_d_valid, in_d_bits_opcode, in_d_bits_param,
             in_d_bits_size, in_d_bits_source, in_d_bits_sink,
             in_d_bits_denied, in_d_bits_data, in_d_bits_corrupt,
             out_a_valid, out_a_bits_opcode, out_a_bits_param, out_a_bits_size,
             out_a_bits_source, out_a_bits_address, out_a_bits_mask,
             out_a_bits_data, out_a_bits_corrupt, out_d_ready
   );

   // Clients plus manager, driven from outside the arbiter
   modport master (
      output in_a_valid, in_a_bits_opcode, in_a_bits_param, in_a_bits_size,
             in_a_bits_source, in_a_bits_address, in_a_bits_mask,
             in_a_bits_data, in_a_bits_corrupt, in_d_ready,
             out_a_ready, out_d_valid, out_d_bits_opcode, out_d_bits_param,
             out_d_bits_size, out_d_bits_source, out_d_bits_sink,
             out_d_bits_denied, out_d_bits_data, out_d_bits_corrupt,
      input  in_a_ready, in_d_valid, in_d_bits_opcode, in_d_bits_param,
             in_d_bits_size, in_d_bits_source, in_d_bits_sink,
             in_d_bits_denied, in_d_bits_data, in_d_bits_corrupt,
             out_a_valid, out_a_bits_opcode, out_a_bits_param, out_a_bits_size,
             out_a_bits_source, out_a_bits_address, out_a_bits_mask,
             out_a_bits_data, out_a_bits_corrupt, out_d_ready
   );

endinterface

// File: rtl/tl_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping, so the
// client at ptr itself has lowest priority.
module tl_rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_any
);
   localparam int unsigned IDX_W = $clog2(N);

   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = IDX_W'((32'(ptr) + i) % N);
         if (!gnt_any && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
            gnt_any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tl_xbar_arb.sv
// N-to-1 TileLink A-channel arbiter with burst locking; D responses are routed
// back statelessly by the upper source-id bits.
module tl_xbar_arb
   import tl_pkg::*;
#(
   parameter int unsigned N_IN   = 4,
   parameter int unsigned SRC_W  = 5,
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned SIZE_W = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   tl_xbar_arb_if.slave bus
);
   localparam int unsigned IDX_W  = $clog2(N_IN);
   localparam int unsigned OSRC_W = SRC_W + IDX_W;
   localparam int unsigned MASK_W = DATA_W / 8;
   localparam int unsigned LG_BB  = $clog2(DATA_W / 8);
   // Wide enough to hold the beat count of the largest encodable size.
   localparam int unsigned BEAT_W = (1 << SIZE_W) - LG_BB;

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [BEAT_W-1:0] beats_q, beats_d;

   logic [N_IN-1:0]   arb_gnt;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_any;
   logic [IDX_W-1:0]  grant;
   logic [N_IN-1:0]   grant_oh;
   logic              sel_valid;
   logic              fire;
   logic              multi;
   logic [BEAT_W-1:0] beats;
   logic [IDX_W-1:0]  d_idx;

   tl_rr_arbiter #(.N(N_IN)) u_arb (
      .req     (bus.in_a_valid),
      .ptr     (last_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   always_comb begin
      grant     = (state_q == ST_IDLE) ? arb_idx : grant_q;
      grant_oh  = '0;
      sel_valid = 1'b0;
      bus.out_a_bits_opcode  = '0;
      bus.out_a_bits_param   = '0;
      bus.out_a_bits_size    = '0;
      bus.out_a_bits_source  = '0;
      bus.out_a_bits_address = '0;
      bus.out_a_bits_mask    = '0;
      bus.out_a_bits_data    = '0;
      bus.out_a_bits_corrupt = 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (grant == IDX_W'(i)) begin
            grant_oh[i]            = 1'b1;
            sel_valid              = bus.in_a_valid[i];
            bus.out_a_bits_opcode  = bus.in_a_bits_opcode[i*TL_OPCODE_W +: TL_OPCODE_W];
            bus.out_a_bits_param   = bus.in_a_bits_param[i*TL_A_PARAM_W +: TL_A_PARAM_W];
            bus.out_a_bits_size    = bus.in_a_bits_size[i*SIZE_W +: SIZE_W];
            bus.out_a_bits_source  = {grant, bus.in_a_bits_source[i*SRC_W +: SRC_W]};
            bus.out_a_bits_address = bus.in_a_bits_address[i*ADDR_W +: ADDR_W];
            bus.out_a_bits_mask    = bus.in_a_bits_mask[i*MASK_W +: MASK_W];
            bus.out_a_bits_data    = bus.in_a_bits_data[i*DATA_W +: DATA_W];
            bus.out_a_bits_corrupt = bus.in_a_bits_corrupt[i];
         end
      end
      if (state_q == ST_IDLE && !arb_any) grant_oh = arb_gnt;
      bus.out_a_valid = reset_n & sel_valid;
      bus.in_a_ready  = reset_n ? (grant_oh & {N_IN{bus.out_a_ready}}) : '0;
      fire  = bus.out_a_valid & bus.out_a_ready;
      multi = ((bus.out_a_bits_opcode == TL_A_PUT_FULL) ||
               (bus.out_a_bits_opcode == TL_A_PUT_PARTIAL)) &&
              (bus.out_a_bits_size > SIZE_W'(LG_BB));
      beats = multi ? (BEAT_W'(1) << (bus.out_a_bits_size - SIZE_W'(LG_BB)))
                    : BEAT_W'(1);
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      beats_d = beats_q;
      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (fire) begin
               if (multi) begin
                  state_d = ST_BURST;
                  grant_d = grant;
                  beats_d = beats - BEAT_W'(1);
               end else begin
                  state_d = ST_IDLE;
                  last_d  = grant;
               end
            end else if (bus.out_a_valid) begin
               state_d = ST_HOLD;
               grant_d = grant;
            end
         end
         ST_BURST: begin
            if (fire) begin
               if (beats_q == BEAT_W'(1)) begin
                  state_d = ST_IDLE;
                  last_d  = grant_q;
                  beats_d = '0;
               end else begin
                  beats_d = beats_q - BEAT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(N_IN - 1);
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beats_q <= beats_d;
      end
   end

   always_comb begin
      d_idx = bus.out_d_bits_source[OSRC_W-1 -: IDX_W];
      bus.in_d_valid  = '0;
      bus.out_d_ready = 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (d_idx == IDX_W'(i)) begin
            bus.in_d_valid[i] = reset_n & bus.out_d_valid;
            bus.out_d_ready   = reset_n & bus.in_d_ready[i];
         end
      end
      bus.in_d_bits_opcode  = bus.out_d_bits_opcode;
      bus.in_d_bits_param   = bus.out_d_bits_param;
      bus.in_d_bits_size    = bus.out_d_bits_size;
      bus.in_d_bits_source  = bus.out_d_bits_source[SRC_W-1:0];
      bus.in_d_bits_sink    = bus.out_d_bits_sink;
      bus.in_d_bits_denied  = bus.out_d_bits_denied;
      bus.in_d_bits_data    = bus.out_d_bits_data;
      bus.in_d_bits_corrupt = bus.out_d_bits_corrupt;
   end

endmodule

// File: tb/tb_tl_xbar_arb.sv
// Directed bench for tl_xbar_arb with N_IN=4: priority, bursts, hold, D routing
// and mid-burst reset.
module tb_tl_xbar_arb;
   import tl_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   tl_xbar_arb_if #(.N_IN(4), .SRC_W(5), .ADDR_W(28), .DATA_W(64), .SIZE_W(4)) bus ();

   tl_xbar_arb #(.N_IN(4), .SRC_W(5), .ADDR_W(28), .DATA_W(64), .SIZE_W(4)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_a(input int c, input logic [2:0] op, input logic [3:0] sz,
                        input logic [4:0] src, input logic [27:0] addr,
                        input logic [63:0] data);
      bus.in_a_bits_opcode[c*3 +: 3]   = op;
      bus.in_a_bits_param[c*3 +: 3]    = 3'd0;
      bus.in_a_bits_size[c*4 +: 4]     = sz;
      bus.in_a_bits_source[c*5 +: 5]   = src;
      bus.in_a_bits_address[c*28 +: 28] = addr;
      bus.in_a_bits_mask[c*8 +: 8]     = 8'hFF;
      bus.in_a_bits_data[c*64 +: 64]   = data;
      bus.in_a_bits_corrupt[c]         = 1'b0;
   endtask

   logic [3:0] fair_exp [6];

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.in_a_valid = '0;        bus.in_a_bits_opcode = '0; bus.in_a_bits_param = '0;
      bus.in_a_bits_size = '0;    bus.in_a_bits_source = '0; bus.in_a_bits_address = '0;
      bus.in_a_bits_mask = '0;    bus.in_a_bits_data = '0;   bus.in_a_bits_corrupt = '0;
      bus.in_d_ready = '1;        bus.out_a_ready = 1'b1;    bus.out_d_valid = 1'b0;
      bus.out_d_bits_opcode = '0; bus.out_d_bits_param = '0; bus.out_d_bits_size = '0;
      bus.out_d_bits_source = '0; bus.out_d_bits_sink = 1'b0; bus.out_d_bits_denied = 1'b0;
      bus.out_d_bits_data = '0;   bus.out_d_bits_corrupt = 1'b0;
      tick();
      tick();

      // Outputs forced quiet while reset is held, even with live requests
      bus.in_a_valid = 4'b0101;
      bus.out_d_valid = 1'b1;
      bus.out_d_bits_source = 7'h60;
      #3;
      chk("rst_out_a_valid", 64'(bus.out_a_valid), 64'd0);
      chk("rst_in_a_ready",  64'(bus.in_a_ready),  64'd0);
      chk("rst_in_d_valid",  64'(bus.in_d_valid),  64'd0);
      chk("rst_out_d_ready", 64'(bus.out_d_ready), 64'd0);
      tick();
      bus.in_a_valid = '0;
      bus.out_d_valid = 1'b0;
      rst_n = 1'b1;

      // Clients 0 and 2 Get together: 0 first, then 2
      set_a(0, TL_A_GET, 4'd3, 5'h03, 28'h0001000, 64'd0);
      set_a(2, TL_A_GET, 4'd3, 5'h11, 28'h0002000, 64'd0);
      bus.in_a_valid = 4'b0101;
      #3;
      chk("g29_valid",  64'(bus.out_a_valid),       64'd1);
      chk("g29_ready0", 64'(bus.in_a_ready),        64'h1);
      chk("g29_src0",   64'(bus.out_a_bits_source), 64'h03);
      chk("g29_addr0",  64'(bus.out_a_bits_address), 64'h0001000);
      tick();
      bus.in_a_valid = 4'b0100;
      #3;
      chk("g29_ready2", 64'(bus.in_a_ready),        64'h4);
      chk("g29_src2",   64'(bus.out_a_bits_source), 64'h51);
      tick();
      bus.in_a_valid = '0;
      #3;
      chk("g29_idle_valid", 64'(bus.out_a_valid), 64'd0);

      // Fairness: three clients streaming single-beat Gets
      set_a(0, TL_A_GET, 4'd3, 5'h00, 28'h0000010, 64'd0);
      set_a(1, TL_A_GET, 4'd3, 5'h01, 28'h0000020, 64'd0);
      set_a(2, TL_A_GET, 4'd3, 5'h02, 28'h0000030, 64'd0);
      fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
      bus.in_a_valid = 4'b0111;
      for (int k = 0; k < 6; k++) begin
         #3;
         chk($sformatf("fair_%0d", k), 64'(bus.in_a_ready), 64'(fair_exp[k]));
         tick();
      end
      bus.in_a_valid = '0;

      // Client 0 alone so client 1 is next in line
      bus.in_a_valid = 4'b0001;
      #3;
      chk("pre_ready0", 64'(bus.in_a_ready), 64'h1);
      tick();
      bus.in_a_valid = '0;

      // Client 1 8-beat PutFull while client 3 waits
      set_a(1, TL_A_PUT_FULL, 4'd6, 5'h07, 28'h0004000, 64'hB000);
      set_a(3, TL_A_GET, 4'd3, 5'h1F, 28'h0008000, 64'd0);
      bus.in_a_valid = 4'b1010;
      for (int k = 0; k < 8; k++) begin
         bus.in_a_bits_data[64 +: 64] = 64'hB000 + 64'(k);
         #3;
         chk($sformatf("burst_beat%0d", k), 64'(bus.in_a_ready), 64'h2);
         tick();
      end
      #3;
      chk("burst_ninth_ready", 64'(bus.in_a_ready),        64'h8);
      chk("burst_ninth_src",   64'(bus.out_a_bits_source), 64'h7F);
      tick();
      bus.in_a_valid = '0;

      // Manager stalls: grant to client 2 must not move when client 0 appears
      bus.out_a_ready = 1'b0;
      set_a(2, TL_A_GET, 4'd3, 5'h02, 28'h0ABC000, 64'hDEAD);
      set_a(0, TL_A_GET, 4'd3, 5'h00, 28'h0000100, 64'h1111);
      bus.in_a_valid = 4'b0100;
      #3;
      chk("hold_valid", 64'(bus.out_a_valid),       64'd1);
      chk("hold_ready", 64'(bus.in_a_ready),        64'h0);
      chk("hold_src1",  64'(bus.out_a_bits_source), 64'h42);
      tick();
      bus.in_a_valid = 4'b0101;
      #3;
      chk("hold_src2",  64'(bus.out_a_bits_source),  64'h42);
      chk("hold_addr2", 64'(bus.out_a_bits_address), 64'h0ABC000);
      tick();
      #3;
      chk("hold_data3", 64'(bus.out_a_bits_data), 64'hDEAD);
      tick();
      bus.out_a_ready = 1'b1;
      #3;
      chk("hold_release", 64'(bus.in_a_ready), 64'h4);
      tick();
      bus.in_a_valid = '0;

      // D routing by upper source bits
      bus.out_d_valid = 1'b1;
      bus.out_d_bits_source = 7'b11_00101;
      bus.out_d_bits_data = 64'hCAFE;
      bus.in_d_ready = 4'b1000;
      #3;
      chk("d_valid3",   64'(bus.in_d_valid),       64'h8);
      chk("d_src3",     64'(bus.in_d_bits_source), 64'h05);
      chk("d_ready3",   64'(bus.out_d_ready),      64'd1);
      chk("d_data",     64'(bus.in_d_bits_data),   64'hCAFE);
      bus.in_d_ready = 4'b0111;
      #1;
      chk("d_ready3_low", 64'(bus.out_d_ready), 64'd0);
      bus.out_d_bits_source = 7'b01_00010;
      bus.in_d_ready = 4'b0010;
      #1;
      chk("d_valid1",   64'(bus.in_d_valid),  64'h2);
      chk("d_ready1",   64'(bus.out_d_ready), 64'd1);
      bus.out_d_valid = 1'b0;
      #1;
      chk("d_idle",     64'(bus.in_d_valid),  64'h0);
      bus.in_d_ready = '1;
      tick();

      // PutFull of exactly one beat is not a burst
      set_a(3, TL_A_PUT_FULL, 4'd3, 5'h03, 28'h0000200, 64'h33);
      set_a(0, TL_A_GET, 4'd3, 5'h00, 28'h0000300, 64'd0);
      bus.in_a_valid = 4'b1001;
      #3;
      chk("one_beat_first", 64'(bus.in_a_ready), 64'h8);
      tick();
      #3;
      chk("one_beat_next",  64'(bus.in_a_ready), 64'h1);
      tick();
      bus.in_a_valid = '0;

      // Reset during beat 4 of an 8-beat burst
      set_a(1, TL_A_PUT_FULL, 4'd6, 5'h09, 28'h0006000, 64'hA5);
      bus.in_a_valid = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         #3;
         chk($sformatf("rb_beat%0d", k), 64'(bus.in_a_ready), 64'h2);
         tick();
      end
      rst_n = 1'b0;
      set_a(0, TL_A_GET, 4'd3, 5'h04, 28'h0000400, 64'd0);
      bus.in_a_valid = 4'b0011;
      #3;
      chk("rb_rst_valid", 64'(bus.out_a_valid), 64'd0);
      chk("rb_rst_ready", 64'(bus.in_a_ready),  64'h0);
      tick();
      rst_n = 1'b1;
      #3;
      chk("rb_after_ready", 64'(bus.in_a_ready),        64'h1);
      chk("rb_after_op",    64'(bus.out_a_bits_opcode), 64'd4);
      chk("rb_after_src",   64'(bus.out_a_bits_source), 64'h04);
      tick();
      bus.in_a_valid = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
